// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise logic unit: eight selectable two-operand ops with zero/negative flags,
// carried through STAGES bubble-collapsing ready/valid register stages.
module bitwise_logic_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_neg
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // a producer holding valid keeps its data stable until that edge, and ready never
    // depends combinationally on valid.
    logic [WIDTH-1:0] res_d;
    logic [STAGES:1]  valid_q;
    logic [STAGES:1]  zero_q;
    logic [STAGES:1]  neg_q;
    logic [WIDTH-1:0] y_q [1:STAGES];
    logic [STAGES:1]  adv;

    always_comb begin
        res_d = in_a;
        case (in_op)
            3'b000:  res_d = ~in_a;
            3'b001:  res_d = in_a & in_b;
            3'b010:  res_d = in_a | in_b;
            3'b011:  res_d = in_a ^ in_b;
            3'b100:  res_d = ~(in_a & in_b);
            3'b101:  res_d = ~(in_a | in_b);
            3'b110:  res_d = ~(in_a ^ in_b);
            default: res_d = in_a;
        endcase
    end

    // A stage may move when the stage after it moves or when it is holding a bubble.
    always_comb begin : adv_chain
        logic run;
        adv = '0;
        run = out_ready | ~valid_q[STAGES];
        adv[STAGES] = run;
        for (int k = STAGES - 1; k >= 1; k--) begin
            run    = run | ~valid_q[k];
            adv[k] = run;
        end
    end

    assign in_ready = adv[1] & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            zero_q  <= '0;
            neg_q   <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            if (adv[1]) begin
                valid_q[1] <= in_valid;
                if (in_valid) begin
                    y_q[1]    <= res_d;
                    zero_q[1] <= ~|res_d;
                    neg_q[1]  <= res_d[WIDTH-1];
                end
            end
            // Payloads only move with real data, so bubbles never disturb held values.
            for (int k = 2; k <= STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        y_q[k]    <= y_q[k-1];
                        zero_q[k] <= zero_q[k-1];
                        neg_q[k]  <= neg_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES];
    assign out_y     = y_q[STAGES];
    assign out_zero  = zero_q[STAGES];
    assign out_neg   = neg_q[STAGES];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe: a 16-bit/2-stage and a 5-bit/1-stage instance checked against
// a truth-table reference model and an in-order expected queue, plus literal directed cases.
module tb_bitwise_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero, a_out_neg;
    logic [15:0] a_in_a, a_in_b, a_out_y;
    logic [2:0]  a_in_op;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_neg;
    logic [4:0]  b_in_a, b_in_b, b_out_y;
    logic [2:0]  b_in_op;

    bitwise_logic_pipe #(.WIDTH(16), .STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_y(a_out_y), .out_zero(a_out_zero), .out_neg(a_out_neg)
    );

    bitwise_logic_pipe #(.WIDTH(5), .STAGES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_y(b_out_y), .out_zero(b_out_zero), .out_neg(b_out_neg)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic rand_ready = 1'b0;

    // Result bit = truth table of the op indexed by {a_bit, b_bit}.
    logic [3:0] tt_tab [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                               4'b0111, 4'b0001, 4'b1001, 4'b1100};

    logic [17:0] exp_a_q [$];  // {y, zero, neg}
    logic [6:0]  exp_b_q [$];

    logic [15:0] d_a [8];
    logic [15:0] d_b [8];
    logic [15:0] d_y [8];
    logic [2:0]  d_op [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] y;
        logic [3:0]  t;
        t = tt_tab[op];
        for (int i = 0; i < 16; i++) y[i] = t[{a[i], b[i]}];
        return y;
    endfunction

    function automatic logic [17:0] exp16(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] y;
        y = ref_op(op, a, b);
        return {y, (y == 16'd0), y[15]};
    endfunction

    function automatic logic [6:0] exp5(input logic [2:0] op, input logic [4:0] a,
                                        input logic [4:0] b);
        logic [15:0] y16;
        logic [4:0]  y;
        y16 = ref_op(op, {11'd0, a}, {11'd0, b});
        y   = y16[4:0];
        return {y, (y == 5'd0), y[4]};
    endfunction

    // Compare process, instance A: every output-valid cycle must show the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a_q.delete();
        end else begin
            check("a_in_ready", 32'(a_in_ready), 32'((exp_a_q.size() < 2) || a_out_ready));
            if (a_out_valid) begin
                if (exp_a_q.size() == 0) begin
                    check("a_unexpected_out", 32'(a_out_valid), 32'd0);
                end else begin
                    check("a_out", 32'({a_out_y, a_out_zero, a_out_neg}), 32'(exp_a_q[0]));
                    if (a_out_ready) void'(exp_a_q.pop_front());
                end
            end
            if (a_in_valid && a_in_ready) exp_a_q.push_back(exp16(a_in_op, a_in_a, a_in_b));
        end
    end

    // Compare process, instance B.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_b_q.delete();
        end else begin
            check("b_in_ready", 32'(b_in_ready), 32'((exp_b_q.size() < 1) || b_out_ready));
            if (b_out_valid) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected_out", 32'(b_out_valid), 32'd0);
                end else begin
                    check("b_out", 32'({b_out_y, b_out_zero, b_out_neg}), 32'(exp_b_q[0]));
                    if (b_out_ready) void'(exp_b_q.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) exp_b_q.push_back(exp5(b_in_op, b_in_a, b_in_b));
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send_a(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int t = 0;
        a_in_valid = 1'b1; a_in_a = a; a_in_b = b; a_in_op = op;
        @(negedge clk);
        while (!a_in_ready && t < 200) begin t++; @(negedge clk); end
        if (!a_in_ready) check("a_send_timeout", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op);
        int t = 0;
        b_in_valid = 1'b1; b_in_a = a; b_in_b = b; b_in_op = op;
        @(negedge clk);
        while (!b_in_ready && t < 200) begin t++; @(negedge clk); end
        if (!b_in_ready) check("b_send_timeout", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // Streams d_* items one per cycle with out_ready=1; item i must appear in cycle i+2.
    task automatic run_dir_a(input int n);
        a_out_ready = 1'b1;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                a_in_valid = 1'b1; a_in_a = d_a[i]; a_in_b = d_b[i]; a_in_op = d_op[i];
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 2) begin
                check("dir_valid", 32'(a_out_valid), 32'd1);
                check("dir_y",     32'(a_out_y),     32'(d_y[i-2]));
                check("dir_zero",  32'(a_out_zero),  32'(d_y[i-2] == 16'd0));
                check("dir_neg",   32'(a_out_neg),   32'(d_y[i-2][15]));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_in_op = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_op = '0; b_out_ready = 1'b1;
        #1;
        check("rst_a_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_y",     32'(a_out_y),     32'd0);
        check("rst_a_flags", 32'({a_out_zero, a_out_neg}), 32'd0);
        check("rst_a_ready", 32'(a_in_ready),  32'd0);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // NOT sweep
        d_a[0] = 16'h5555; d_a[1] = 16'hCCCC; d_a[2] = 16'h85DD; d_a[3] = 16'h0515;
        d_y[0] = 16'hAAAA; d_y[1] = 16'h3333; d_y[2] = 16'h7A22; d_y[3] = 16'hFAEA;
        for (int i = 0; i < 4; i++) begin d_b[i] = 16'($urandom); d_op[i] = 3'b000; end
        run_dir_a(4);

        // all eight ops on fixed operands
        for (int i = 0; i < 8; i++) begin d_a[i] = 16'hF0F0; d_b[i] = 16'hFF00; d_op[i] = 3'(i); end
        d_y[0] = 16'h0F0F; d_y[1] = 16'hF000; d_y[2] = 16'hFFF0; d_y[3] = 16'h0FF0;
        d_y[4] = 16'h0FFF; d_y[5] = 16'h000F; d_y[6] = 16'hF00F; d_y[7] = 16'hF0F0;
        run_dir_a(8);

        // zero-flag cases
        d_a[0] = 16'hFFFF; d_b[0] = 16'h0000; d_op[0] = 3'b000; d_y[0] = 16'h0000;
        d_a[1] = 16'h1234; d_b[1] = 16'h1234; d_op[1] = 3'b011; d_y[1] = 16'h0000;
        run_dir_a(2);

        // backpressure: two accepted, third held off until out_ready rises
        a_out_ready = 1'b0;
        send_a(16'h1111, 16'h0000, 3'b000);
        send_a(16'h00FF, 16'h0F0F, 3'b001);
        a_in_valid = 1'b1; a_in_a = 16'h8000; a_in_b = 16'h0000; a_in_op = 3'b111;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready",   32'(a_in_ready),  32'd0);
            check("bp_hold_valid", 32'(a_out_valid), 32'd1);
            check("bp_hold_y",     32'(a_out_y),     32'h0000EEEE);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(a_in_ready), 32'd1);
        check("bp_drain0", 32'(a_out_y), 32'h0000EEEE);
        @(posedge clk); #1; a_in_valid = 1'b0;
        @(negedge clk);
        check("bp_drain1", 32'(a_out_y), 32'h0000000F);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_drain2", 32'(a_out_y), 32'h00008000);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_empty", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;

        // reset with two results in flight
        a_out_ready = 1'b0;
        send_a(16'h1234, 16'h0000, 3'b000);
        send_a(16'h4321, 16'hFFFF, 3'b011);
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_y",     32'(a_out_y),     32'd0);
        check("mid_rst_flags", 32'({a_out_zero, a_out_neg}), 32'd0);
        check("mid_rst_ready", 32'(a_in_ready),  32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1; a_out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale", 32'(a_out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // 5-bit, single-stage instance
        b_in_valid = 1'b1; b_in_a = 5'b10110; b_in_b = 5'b00000; b_in_op = 3'b000;
        @(posedge clk); #1; b_in_valid = 1'b0;
        @(negedge clk);
        check("w5_valid", 32'(b_out_valid), 32'd1);
        check("w5_y",     32'(b_out_y),     32'h09);
        check("w5_flags", 32'({b_out_zero, b_out_neg}), 32'd0);
        @(posedge clk); #1;

        // random streams with random backpressure on both instances
        rand_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin a_in_valid = 1'b0; @(posedge clk); #1; end
                    send_a(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
                end
                a_in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin b_in_valid = 1'b0; @(posedge clk); #1; end
                    send_b(5'($urandom), 5'($urandom), 3'($urandom_range(0, 7)));
                end
                b_in_valid = 1'b0;
            end
        join
        rand_ready = 1'b0;
        @(posedge clk); #2;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int t = 0; t < 100 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); t++) @(negedge clk);
        check("drain_a", 32'(exp_a_q.size()), 32'd0);
        check("drain_b", 32'(exp_b_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
